// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through cache.
package cache_pkg;

    localparam int BLOCK_SIZE = 4;
    localparam int OFFSET_W   = 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COMPARE    = 3'd1,
        REFILL_REQ = 3'd2,
        REFILL     = 3'd3,
        WRITE_REQ  = 3'd4,
        WRITE_WAIT = 3'd5,
        RESPOND    = 3'd6
    } state_t;

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int addr_width, input int num_lines);
        return addr_width - OFFSET_W - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/cache_if.sv
// CPU-side request/response and memory-side block-read/word-write signals of the cache.
interface cache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_rd_en;
    logic                  cpu_wr_en;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wr_data;
    logic [DATA_WIDTH-1:0] cpu_rd_data;
    logic                  cpu_ready;
    logic                  cpu_done;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_valid;
    logic                  mem_ready;
    logic                  mem_done;

    // Controller view
    modport slave (
        input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data,
        output cpu_rd_data, cpu_ready, cpu_done,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_rd_valid, mem_ready, mem_done
    );

    // CPU plus memory environment view
    modport master (
        output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data,
        input  cpu_rd_data, cpu_ready, cpu_done,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        output mem_rd_data, mem_rd_valid, mem_ready, mem_done
    );
endinterface

// File: rtl/cache_line_array.sv
// Tag, valid and data storage: one write port (word and/or tag+valid), one combinational read port.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 16,
    parameter int TAG_W      = 26,
    parameter int IDX_W      = index_width(NUM_LINES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  word_we,
    input  logic                  tag_we,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [OFFSET_W-1:0]   wr_offset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [IDX_W-1:0]      rd_index,
    input  logic [OFFSET_W-1:0]   rd_offset,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid
);

    logic [DATA_WIDTH-1:0] data_r [NUM_LINES][BLOCK_SIZE];
    logic [TAG_W-1:0]      tag_r  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_r;

    // Data and tag storage carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_r[wr_index][wr_offset] <= wr_data;
        end
        if (tag_we) begin
            tag_r[wr_index] <= wr_tag;
        end
    end

    // Valid bits are cleared on reset so an abandoned refill never becomes visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (tag_we) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    assign rd_data  = data_r[rd_index][rd_offset];
    assign rd_tag   = tag_r[rd_index];
    assign rd_valid = valid_r[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 4-word blocks.
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
module cache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    cache_if.slave      bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = index_width(NUM_LINES);
    localparam int TAG_W = tag_width(ADDR_WIDTH, NUM_LINES);

    state_t                state_r;
    state_t                next_state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  op_wr_r;
    logic [1:0]            cnt_r;

    logic                  cpu_ready_r;
    logic                  cpu_done_r;
    logic [DATA_WIDTH-1:0] cpu_rd_data_r;
    logic                  mem_rd_en_r;
    logic                  mem_wr_en_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wr_data_r;

    logic [IDX_W-1:0]      idx_s;
    logic [OFFSET_W-1:0]   off_s;
    logic [TAG_W-1:0]      tag_s;
    logic                  hit_s;
    logic                  word_we_s;
    logic                  tag_we_s;
    logic [OFFSET_W-1:0]   wr_offset_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [DATA_WIDTH-1:0] resp_data_s;
    logic [DATA_WIDTH-1:0] arr_data_s;
    logic [TAG_W-1:0]      arr_tag_s;
    logic                  arr_valid_s;

    assign idx_s = addr_r[OFFSET_W +: IDX_W];
    assign off_s = addr_r[OFFSET_W-1:0];
    assign tag_s = addr_r[ADDR_WIDTH-1 -: TAG_W];
    assign hit_s = arr_valid_s && (arr_tag_s == tag_s);

    cache_line_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LINES  (NUM_LINES),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W)
    ) u_lines (
        .clk       (clk),
        .reset     (reset),
        .word_we   (word_we_s),
        .tag_we    (tag_we_s),
        .wr_index  (idx_s),
        .wr_offset (wr_offset_s),
        .wr_data   (wr_data_s),
        .wr_tag    (tag_s),
        .rd_index  (idx_s),
        .rd_offset (off_s),
        .rd_data   (arr_data_s),
        .rd_tag    (arr_tag_s),
        .rd_valid  (arr_valid_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, array write controls and response data selection.
    always_comb begin
        next_state_s = state_r;
        word_we_s    = 1'b0;
        tag_we_s     = 1'b0;
        wr_offset_s  = off_s;
        wr_data_s    = wdata_r;
        resp_data_s  = arr_data_s;
        case (state_r)
            IDLE: begin
                if (bus.cpu_rd_en || bus.cpu_wr_en) begin
                    next_state_s = COMPARE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COMPARE: begin
                if (op_wr_r) begin
                    word_we_s    = hit_s;
                    next_state_s = WRITE_REQ;
                end else if (hit_s) begin
                    next_state_s = RESPOND;
                end else begin
                    next_state_s = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                if (bus.mem_ready) begin
                    next_state_s = REFILL;
                end else begin
                    next_state_s = REFILL_REQ;
                end
            end
            REFILL: begin
                wr_offset_s = cnt_r;
                wr_data_s   = bus.mem_rd_data;
                // The final word is still in flight when the requested word is the last one.
                if (cnt_r == off_s) begin
                    resp_data_s = bus.mem_rd_data;
                end else begin
                    resp_data_s = arr_data_s;
                end
                if (bus.mem_rd_valid) begin
                    word_we_s    = 1'b1;
                    tag_we_s     = (cnt_r == 2'd3);
                    next_state_s = (cnt_r == 2'd3) ? RESPOND : REFILL;
                end else begin
                    next_state_s = REFILL;
                end
            end
            WRITE_REQ: begin
                if (bus.mem_ready) begin
                    next_state_s = WRITE_WAIT;
                end else begin
                    next_state_s = WRITE_REQ;
                end
            end
            WRITE_WAIT: begin
                if (bus.mem_done) begin
                    next_state_s = RESPOND;
                end else begin
                    next_state_s = WRITE_WAIT;
                end
            end
            RESPOND: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Request capture, refill word counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r        <= {ADDR_WIDTH{1'b0}};
            wdata_r       <= {DATA_WIDTH{1'b0}};
            op_wr_r       <= 1'b0;
            cnt_r         <= 2'd0;
            cpu_ready_r   <= 1'b1;
            cpu_done_r    <= 1'b0;
            cpu_rd_data_r <= {DATA_WIDTH{1'b0}};
            mem_rd_en_r   <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_addr_r    <= {ADDR_WIDTH{1'b0}};
            mem_wr_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (state_r == IDLE && (bus.cpu_rd_en || bus.cpu_wr_en)) begin
                addr_r  <= bus.cpu_addr;
                wdata_r <= bus.cpu_wr_data;
                op_wr_r <= ~bus.cpu_rd_en;
            end
            if (state_r == REFILL_REQ) begin
                cnt_r <= 2'd0;
            end else if (state_r == REFILL && bus.mem_rd_valid) begin
                cnt_r <= cnt_r + 2'd1;
            end
            cpu_ready_r <= (next_state_s == IDLE);
            cpu_done_r  <= (next_state_s == RESPOND);
            if (next_state_s == RESPOND && !op_wr_r) begin
                cpu_rd_data_r <= resp_data_s;
            end
            mem_rd_en_r <= (state_r == REFILL_REQ) && bus.mem_ready;
            mem_wr_en_r <= (state_r == WRITE_REQ) && bus.mem_ready;
            if (state_r == REFILL_REQ && bus.mem_ready) begin
                mem_addr_r <= {tag_s, idx_s, {OFFSET_W{1'b0}}};
            end else if (state_r == WRITE_REQ && bus.mem_ready) begin
                mem_addr_r    <= addr_r;
                mem_wr_data_r <= wdata_r;
            end
        end
    end

    assign bus.cpu_ready   = cpu_ready_r;
    assign bus.cpu_done    = cpu_done_r;
    assign bus.cpu_rd_data = cpu_rd_data_r;
    assign bus.mem_rd_en   = mem_rd_en_r;
    assign bus.mem_wr_en   = mem_wr_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wr_data = mem_wr_data_r;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Saturating tallies of every COMPARE outcome, reads and writes alike.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (state_r == COMPARE) begin
            if (hit_s && hit_count_r != 32'hFFFF_FFFF) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (!hit_s && miss_count_r != 32'hFFFF_FFFF) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with a 4-word burst memory model (word i = 1000+i).
module tb_cache_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_controller #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_LINES  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Memory model state
    logic [31:0] mem_arr [0:255];
    int rd_count = 0;
    int wr_count = 0;
    int words_sent = 0;
    int pend = 0;
    int done_dly = 0;
    bit phase = 1'b0;
    logic [31:0] burst_addr = 32'd0;
    logic [31:0] last_rd_addr = 32'd0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%h) exp %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Memory: refill words on alternate cycles, write done two cycles after the strobe.
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'd1000 + 32'(i);
        bus.mem_ready    = 1'b1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_done     = 1'b0;
        bus.mem_rd_data  = 32'hBADB_AD00;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rd_valid = 1'b0;
            bus.mem_done     = 1'b0;
            bus.mem_rd_data  = 32'hBADB_AD00;
            if (reset) begin
                pend     = 0;
                done_dly = 0;
            end else begin
                if (pend > 0) begin
                    phase = ~phase;
                    if (phase) begin
                        bus.mem_rd_valid = 1'b1;
                        bus.mem_rd_data  = mem_arr[8'(burst_addr + 32'(4 - pend))];
                        pend--;
                        words_sent++;
                    end
                end
                if (bus.mem_rd_en) begin
                    rd_count++;
                    last_rd_addr = bus.mem_addr;
                    burst_addr   = bus.mem_addr;
                    pend         = 4;
                    words_sent   = 0;
                    phase        = 1'b0;
                end
                if (bus.mem_wr_en) begin
                    wr_count++;
                    last_wr_addr = bus.mem_addr;
                    last_wr_data = bus.mem_wr_data;
                    mem_arr[8'(bus.mem_addr)] = bus.mem_wr_data;
                    done_dly = 2;
                end else if (done_dly > 0) begin
                    done_dly--;
                    if (done_dly == 0) bus.mem_done = 1'b1;
                end
            end
            bus.mem_ready = (pend == 0) && (done_dly == 0);
        end
    end

    task automatic issue_req(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp);
        int n = 0;
        while (bus.cpu_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value("ready_before_req", {31'd0, bus.cpu_ready}, 32'd1);
        bus.cpu_rd_en   = rd;
        bus.cpu_wr_en   = wr;
        bus.cpu_addr    = addr;
        bus.cpu_wr_data = wdata;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.cpu_rd_en = 1'b0;
        bus.cpu_wr_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 1;
        logic [31:0] exp;
        while (bus.cpu_done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_value({tag, "_done_seen"}, {31'd0, bus.cpu_done}, 32'd1);
        if (exp_lat > 0) check_value({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check_value({tag, "_rd_data"}, bus.cpu_rd_data, exp);
        @(posedge clk);
        #1;
        check_value({tag, "_done_pulse"}, {31'd0, bus.cpu_done}, 32'd0);
        check_value({tag, "_ready_after"}, {31'd0, bus.cpu_ready}, 32'd1);
    endtask

    task automatic do_req(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int exp_lat);
        issue_req(rd, wr, addr, wdata, exp);
        wait_done(tag, exp_lat);
    endtask

    task automatic apply_reset(input int cycles);
        #1;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int rd0;
        int wr0;
        int n;
        bus.cpu_rd_en   = 1'b0;
        bus.cpu_wr_en   = 1'b0;
        bus.cpu_addr    = 32'd0;
        bus.cpu_wr_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_value("rst_ready",     {31'd0, bus.cpu_ready}, 32'd1);
        check_value("rst_done",      {31'd0, bus.cpu_done},  32'd0);
        check_value("rst_rd_data",   bus.cpu_rd_data,        32'd0);
        check_value("rst_mem_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        check_value("rst_mem_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        check_value("rst_mem_addr",  bus.mem_addr,           32'd0);
        check_value("rst_mem_wdata", bus.mem_wr_data,        32'd0);

        // Cold read miss then hit in the same block
        rd0 = rd_count;
        do_req("cold_40", 1'b1, 1'b0, 32'h40, 32'd0, 32'd1064, 0);
        check_value("cold_40_refills", 32'(rd_count - rd0), 32'd1);
        check_value("cold_40_mem_addr", last_rd_addr, 32'h40);
        check_value("cold_40_words", 32'(words_sent), 32'd4);
        rd0 = rd_count;
        do_req("hit_42", 1'b1, 1'b0, 32'h42, 32'd0, 32'd1066, 2);
        check_value("hit_42_refills", 32'(rd_count - rd0), 32'd0);
`ifdef CACHE_STATS_EN
        check_value("stats_hit", hit_count, 32'd1);
        check_value("stats_miss", miss_count, 32'd1);
`endif

        // Read and write both requested: the read wins
        wr0 = wr_count;
        do_req("both_43", 1'b1, 1'b1, 32'h43, 32'h777, 32'd1067, 2);
        check_value("both_43_no_write", 32'(wr_count - wr0), 32'd0);

        // Write hit goes through to memory, read data output is left alone
        wr0 = wr_count;
        do_req("wr_41", 1'b0, 1'b1, 32'h41, 32'hDEAD, 32'd1067, 0);
        check_value("wr_41_writes", 32'(wr_count - wr0), 32'd1);
        check_value("wr_41_addr", last_wr_addr, 32'h41);
        check_value("wr_41_data", last_wr_data, 32'hDEAD);
        rd0 = rd_count;
        do_req("hit_41", 1'b1, 1'b0, 32'h41, 32'd0, 32'hDEAD, 2);
        check_value("hit_41_refills", 32'(rd_count - rd0), 32'd0);

        // Reset clears the cache; conflicting blocks evict each other
        apply_reset(2);
        check_value("rst2_rd_data", bus.cpu_rd_data, 32'd0);
        rd0 = rd_count;
        do_req("conf_a", 1'b1, 1'b0, 32'h40, 32'd0, 32'd1064, 0);
        do_req("conf_b", 1'b1, 1'b0, 32'h80, 32'd0, 32'd1128, 0);
        check_value("conf_b_addr", last_rd_addr, 32'h80);
        do_req("conf_c", 1'b1, 1'b0, 32'h40, 32'd0, 32'd1064, 0);
        check_value("conf_refills", 32'(rd_count - rd0), 32'd3);

        // Write miss is not allocated
        rd0 = rd_count;
        wr0 = wr_count;
        do_req("wmiss_80", 1'b0, 1'b1, 32'h80, 32'h5, 32'd1064, 0);
        check_value("wmiss_no_refill", 32'(rd_count - rd0), 32'd0);
        check_value("wmiss_writes", 32'(wr_count - wr0), 32'd1);
        do_req("rd_80", 1'b1, 1'b0, 32'h80, 32'd0, 32'd5, 0);
        check_value("rd_80_refills", 32'(rd_count - rd0), 32'd1);

        // Reset after refill word 1 abandons the line
        issue_req(1'b1, 1'b0, 32'h44, 32'd0, 32'd0);
        n = 0;
        while (words_sent < 2 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_value("mid_words_reached", 32'(words_sent >= 2), 32'd1);
        @(posedge clk);
        apply_reset(2);
        check_value("mid_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check_value("mid_done", {31'd0, bus.cpu_done}, 32'd0);
        check_value("mid_rd_data", bus.cpu_rd_data, 32'd0);
        rd0 = rd_count;
        do_req("mid_44", 1'b1, 1'b0, 32'h44, 32'd0, 32'd1068, 0);
        check_value("mid_44_refills", 32'(rd_count - rd0), 32'd1);

        // Requested word is the last refill word, then a hit in that block
        do_req("cold_4b", 1'b1, 1'b0, 32'h4B, 32'd0, 32'd1075, 0);
        rd0 = rd_count;
        do_req("hit_48", 1'b1, 1'b0, 32'h48, 32'd0, 32'd1072, 2);
        check_value("hit_48_refills", 32'(rd_count - rd0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, word width; ADDR_WIDTH, 32, word-address width; NUM_LINES, 16, direct-mapped lines (power of two, at least 2).
REQ-002 Ports SHALL be, name direction width meaning: clk in 1 sole clock, rising edge; reset in 1 synchronous active-high reset.
REQ-003 cpu_rd_en in 1 read request; cpu_wr_en in 1 write request; cpu_addr in ADDR_WIDTH word address; cpu_wr_data in DATA_WIDTH write data.
REQ-004 cpu_rd_data out DATA_WIDTH read result; cpu_ready out 1 request accepted this cycle; cpu_done out 1 one-cycle completion pulse.
REQ-005 mem_rd_en out 1 block-read strobe; mem_wr_en out 1 word-write strobe; mem_addr out ADDR_WIDTH; mem_wr_data out DATA_WIDTH.
REQ-006 mem_rd_data in DATA_WIDTH refill word; mem_rd_valid in 1 refill word valid; mem_ready in 1 memory idle; mem_done in 1 write complete.

Function
REQ-007 Address split SHALL be offset=addr[1:0] (4-word block), index=next log2(NUM_LINES) bits, tag=remaining upper bits.
REQ-008 Policy SHALL be write-through, no-write-allocate; write hit updates the cached word and memory.
REQ-009 FSM states SHALL be IDLE, COMPARE, REFILL_REQ, REFILL, WRITE_REQ, WRITE_WAIT, RESPOND.
REQ-010 IDLE: cpu_ready=1; on cpu_rd_en or cpu_wr_en, address/data/op are latched -> COMPARE; rd_en wins when both high.
REQ-011 COMPARE: read hit -> RESPOND; read miss -> REFILL_REQ; any write -> WRITE_REQ (cache word written same edge on hit).
REQ-012 REFILL_REQ: waits for mem_ready=1, then asserts mem_rd_en for exactly one cycle with mem_addr={tag,index,2'b00} -> REFILL.
REQ-013 REFILL: each mem_rd_valid cycle writes mem_rd_data at word counter 0..3; after word 3, tag is stored, valid is set -> RESPOND.
REQ-014 WRITE_REQ: waits for mem_ready=1, asserts mem_wr_en one cycle with latched address/data -> WRITE_WAIT; on mem_done -> RESPOND.
REQ-015 RESPOND: cpu_done=1 for one cycle; cpu_rd_data=requested word for reads, unchanged for writes -> IDLE.
REQ-016 Latency SHALL be: read hit cpu_done exactly 2 cycles after acceptance; misses are memory-dependent.
REQ-017 cpu_ready SHALL be 0 outside IDLE; requests not accepted are ignored, not queued.
REQ-018 mem_rd_valid outside REFILL and mem_done outside WRITE_WAIT SHALL be ignored.
REQ-019 cpu_rd_data SHALL hold its value until the next read completes.

Reset
REQ-020 Reset SHALL force IDLE, clear all valid bits and the word counter, and set cpu_rd_data=0, cpu_done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0; cpu_ready=1 the cycle after.
REQ-021 Reset mid-refill or mid-write SHALL abandon the transaction; the line is not marked valid.
REQ-022 Data/tag arrays SHALL NOT require reset.

Configuration
REQ-023 Macro CACHE_STATS_EN defined: outputs hit_count and miss_count, 32 bits each, SHALL count COMPARE outcomes (writes included), clear on reset, and saturate at all-ones.
REQ-024 CACHE_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package cache_pkg SHALL hold the FSM state enum, BLOCK_SIZE=4, OFFSET_W=2, and the tag/index width helper functions.
REQ-026 Sub-module cache_line_array SHALL hold the tag, valid, and data storage: one write port (word or tag+valid) and one combinational read port.

Verification
REQ-027 Memory model word i=1000+i; read addr 0x40 cold -> one mem_rd_en at 0x40, 4 refill words, cpu_rd_data=1064, then read 0x42 hit -> 1066 with cpu_done 2 cycles after accept.
REQ-028 Write 0x41=0xDEAD after REQ-027 -> one mem_wr_en at 0x41; after mem_done, read 0x41 hit -> 0xDEAD with no mem_rd_en.
REQ-029 Write miss 0x80=0x5 then read 0x80 -> write is not allocated; read issues refill and returns 0x5.
REQ-030 Conflict: read 0x40 then 0x40+4*NUM_LINES, then 0x40 -> three refills; returns 1064, 1128, 1064.
REQ-031 cpu_rd_en and cpu_wr_en both high -> read performed; reset asserted in REFILL after word 1 -> IDLE, next read of same block refills.
REQ-032 With CACHE_STATS_EN, REQ-027 sequence -> hit_count=1, miss_count=1.
